// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state encodings and default widths for the Fibonacci generator
package fib_pkg;

  localparam int FIB_N     = 4;
  localparam int FIB_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fib_step.sv
// rtl/fib_step.sv - one Fibonacci step: N+1-bit add of the two previous terms
module fib_step
  import fib_pkg::*;
#(
  parameter int N = FIB_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_seq_gen.sv
// rtl/fib_seq_gen.sv - valid/ready Fibonacci term generator with count limit and overflow stop
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int N     = FIB_N,
  parameter int CNT_W = FIB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  fib_state_e       state, state_nxt;
  logic [N-1:0]     a, b, a_nxt, b_nxt, sum;
  logic             carry;
  logic             pend, pend_nxt;
  logic [CNT_W-1:0] rem, rem_nxt, rem_dec;
  logic             ovf_nxt;
  logic             accept;

  fib_step #(.N(N)) u_step (
    .a     (a),
    .b     (b),
    .sum   (sum),
    .carry (carry)
  );

  assign accept  = out_valid && out_ready;
  assign rem_dec = rem - CNT_W'(1);

  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    b_nxt     = b;
    rem_nxt   = rem;
    pend_nxt  = pend;
    ovf_nxt   = overflow;
    case (state)
      ST_IDLE: begin
        if (start) begin
          ovf_nxt   = 1'b0;
          a_nxt     = '0;
          b_nxt     = N'(1);
          rem_nxt   = count;
          pend_nxt  = 1'b0;
          state_nxt = (count == '0) ? ST_DONE : ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (accept) begin
          rem_nxt = rem_dec;
          if (rem_dec == '0) begin
            state_nxt = ST_DONE;
          end else if (pend) begin
            // b already lost its carry: the next term does not fit in N bits
            state_nxt = ST_DONE;
            ovf_nxt   = 1'b1;
          end else begin
            a_nxt    = b;
            b_nxt    = sum;
            pend_nxt = carry;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a         <= '0;
      b         <= '0;
      rem       <= '0;
      pend      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      rem       <= rem_nxt;
      pend      <= pend_nxt;
      out_valid <= (state_nxt == ST_EMIT);
      out_data  <= (state_nxt == ST_EMIT) ? a_nxt : '0;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
      overflow  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// tb/tb_fib_seq_gen.sv - self-checking bench for fib_seq_gen against a list-based Fibonacci model
module tb_fib_seq_gen;

  localparam int N     = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             out_ready;
  logic             out_valid;
  logic [N-1:0]     out_data;
  logic             busy;
  logic             done;
  logic             overflow;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  bit exp_ovf;

  typedef struct {
    int cnt;
    int mode;
    bit glitch;
    int beats;
    bit ovf;
  } vec_t;

  vec_t tbl[6];

  fib_seq_gen #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit is_fib4(int v);
    return v inside {0, 1, 2, 3, 5, 8, 13};
  endfunction

  // Terms are listed in order until the count is reached or a term no longer fits in N bits
  task automatic build_model(int cnt);
    int f0 = 0;
    int f1 = 1;
    int t;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int k = 0; k < cnt; k++) begin
      if (f0 >= (1 << N)) begin
        exp_ovf = 1'b1;
        break;
      end
      exp_q.push_back(f0);
      t  = f0 + f1;
      f0 = f1;
      f1 = t;
    end
  endtask

  task automatic run_seq(int cnt, int mode, bit glitch, int exp_beats, bit exp_o);
    int  beats = 0;
    int  cyc = 0;
    bit  got_done = 0;
    bit  stalled = 0;
    int  held = 0;
    bit  rdy;
    build_model(cnt);
    @(negedge clk);
    start = 1'b1;
    count = CNT_W'(cnt);
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("latency_valid", out_valid, (cnt != 0) ? 1 : 0);
    while (cyc < 200) begin
      if (done) begin
        got_done = 1;
        start = 1'b0;
        out_ready = 1'b0;
        break;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held);
      end
      if (out_valid) chk("busy_emit", busy, 1);
      if (out_valid && rdy) begin
        if (beats < exp_q.size()) chk("term", out_data, exp_q[beats]);
        if (glitch) chk("detector", is_fib4(out_data), 1);
        beats++;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        held = out_data;
      end
      start = (glitch && out_valid) ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc++;
      @(negedge clk);
    end
    chk("done_seen", got_done, 1);
    chk("beats", beats, exp_beats);
    chk("overflow", overflow, exp_o);
    chk("valid_at_done", out_valid, 0);
    chk("busy_at_done", busy, 1);
    if (mode == 0) chk("throughput", cyc, beats);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("ovf_sticky", overflow, exp_o);
  endtask

  initial begin
    int rc, rm;
    bit rg;
    rst_n = 1'b0;
    start = 1'b0;
    count = '0;
    out_ready = 1'b0;

    tbl[0] = '{cnt: 8,  mode: 0, glitch: 0, beats: 8, ovf: 0};
    tbl[1] = '{cnt: 12, mode: 0, glitch: 0, beats: 8, ovf: 1};
    tbl[2] = '{cnt: 0,  mode: 0, glitch: 0, beats: 0, ovf: 0};
    tbl[3] = '{cnt: 5,  mode: 1, glitch: 0, beats: 5, ovf: 0};
    tbl[4] = '{cnt: 15, mode: 2, glitch: 1, beats: 8, ovf: 1};
    tbl[5] = '{cnt: 9,  mode: 1, glitch: 1, beats: 8, ovf: 1};

    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_seq(tbl[i].cnt, tbl[i].mode, tbl[i].glitch, tbl[i].beats, tbl[i].ovf);

    // Reset in the middle of a sequence, then restart from F0
    @(negedge clk);
    start = 1'b1;
    count = CNT_W'(8);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_data", out_data, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(negedge clk);
    chk("no_done_after_rst", done, 0);
    run_seq(3, 0, 0, 3, 0);

    for (int i = 0; i < 8; i++) begin
      rc = $urandom_range(0, 15);
      rm = $urandom_range(0, 2);
      rg = 1'($urandom_range(0, 1));
      build_model(rc);
      run_seq(rc, rm, rg, exp_q.size(), exp_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
